// File: rtl/mypackage.sv
// Shared types for the oscillator bank and its controllers.
package mypackage;

    localparam int unsigned FREQ_BITS = 32;

    // Unsigned Q16.16 frequency in Hz, as consumed by nco.freq.
    typedef logic [FREQ_BITS-1:0] frequency;

endpackage

// File: rtl/voice_allocator.sv
// Polyphony allocator: maps note-on/off events onto VOICES nco voices, scanning one
// voice per cycle and stealing the least recently allocated voice when all are busy.
module voice_allocator #(
    parameter int unsigned VOICES    = 4,
    parameter int unsigned NOTE_BITS = 7,
    parameter int unsigned AGE_BITS  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 ev_valid,
    output logic                 ev_ready,
    input  logic                 ev_on,
    input  logic [NOTE_BITS-1:0] ev_note,
    input  mypackage::frequency  ev_freq,
    output mypackage::frequency  voice_freq [VOICES],
    output logic [VOICES-1:0]    voice_enable,
    output logic [VOICES-1:0]    voice_restart,
    output logic                 stolen
);
    localparam int unsigned         IDX_W    = (VOICES > 1) ? $clog2(VOICES) : 1;
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(VOICES - 1);
    localparam logic [AGE_BITS-1:0] AGE_MAX  = '1;

    typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, COMMIT = 2'd2} state_e;

    state_e state_q, state_d;
    logic   accept_c, scan_c, commit_c;

    logic                 ev_ready_q, ev_ready_d;
    logic                 lat_on_q, lat_on_d;
    logic [NOTE_BITS-1:0] lat_note_q, lat_note_d;
    mypackage::frequency  lat_freq_q, lat_freq_d;

    logic [IDX_W-1:0]     idx_q, idx_d;
    logic                 match_vld_q, match_vld_d;
    logic [IDX_W-1:0]     match_idx_q, match_idx_d;
    logic                 free_vld_q, free_vld_d;
    logic [IDX_W-1:0]     free_idx_q, free_idx_d;
    logic [IDX_W-1:0]     old_idx_q, old_idx_d;
    logic [AGE_BITS-1:0]  old_age_q, old_age_d;
    logic [IDX_W-1:0]     target_c;

    logic [VOICES-1:0]    active_q, active_d;
    logic [NOTE_BITS-1:0] note_q [VOICES];
    logic [NOTE_BITS-1:0] note_d [VOICES];
    mypackage::frequency  freq_q [VOICES];
    mypackage::frequency  freq_d [VOICES];
    logic [AGE_BITS-1:0]  age_q  [VOICES];
    logic [AGE_BITS-1:0]  age_d  [VOICES];

    logic [VOICES-1:0]    restart_pend_q, restart_pend_d;
    logic                 stolen_pend_q, stolen_pend_d;

    logic [VOICES-1:0]    voice_enable_q, voice_enable_d;
    logic [VOICES-1:0]    voice_restart_q, voice_restart_d;
    logic                 stolen_q, stolen_d;
    mypackage::frequency  voice_freq_q [VOICES];
    mypackage::frequency  voice_freq_d [VOICES];

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = SCAN;
            SCAN:    if (idx_q == IDX_LAST) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        accept_c   = (state_q == IDLE) && ev_ready_q && ev_valid;
        scan_c     = (state_q == SCAN);
        commit_c   = (state_q == COMMIT);
        ev_ready_d = (state_d == IDLE);
    end

    // Event latch, per-voice scan and commit of the chosen voice.
    always_comb begin
        lat_on_d       = lat_on_q;
        lat_note_d     = lat_note_q;
        lat_freq_d     = lat_freq_q;
        idx_d          = idx_q;
        match_vld_d    = match_vld_q;
        match_idx_d    = match_idx_q;
        free_vld_d     = free_vld_q;
        free_idx_d     = free_idx_q;
        old_idx_d      = old_idx_q;
        old_age_d      = old_age_q;
        active_d       = active_q;
        note_d         = note_q;
        freq_d         = freq_q;
        age_d          = age_q;
        restart_pend_d = '0;
        stolen_pend_d  = 1'b0;

        target_c = old_idx_q;
        if (match_vld_q)     target_c = match_idx_q;
        else if (free_vld_q) target_c = free_idx_q;

        if (accept_c) begin
            lat_on_d    = ev_on;
            lat_note_d  = ev_note;
            lat_freq_d  = ev_freq;
            idx_d       = '0;
            match_vld_d = 1'b0;
            match_idx_d = '0;
            free_vld_d  = 1'b0;
            free_idx_d  = '0;
            old_idx_d   = '0;
            old_age_d   = '0;
        end

        if (scan_c) begin
            idx_d = idx_q + 1'b1;
            if (!match_vld_q && active_q[idx_q] && (note_q[idx_q] == lat_note_q)) begin
                match_vld_d = 1'b1;
                match_idx_d = idx_q;
            end
            if (!free_vld_q && !active_q[idx_q]) begin
                free_vld_d = 1'b1;
                free_idx_d = idx_q;
            end
            // Strict compare keeps the lowest index among equally old voices.
            if (age_q[idx_q] > old_age_q) begin
                old_age_d = age_q[idx_q];
                old_idx_d = idx_q;
            end
        end

        if (commit_c) begin
            if (lat_on_q) begin
                for (int unsigned v = 0; v < VOICES; v++) begin
                    if (IDX_W'(v) == target_c) begin
                        note_d[v]         = lat_note_q;
                        freq_d[v]         = lat_freq_q;
                        active_d[v]       = 1'b1;
                        age_d[v]          = '0;
                        restart_pend_d[v] = 1'b1;
                    end else if (age_q[v] != AGE_MAX) begin
                        age_d[v] = age_q[v] + 1'b1;
                    end
                end
                stolen_pend_d = !match_vld_q && !free_vld_q;
            end else if (match_vld_q) begin
                active_d[match_idx_q] = 1'b0;
            end
        end
    end

    // Output staging: voice state is presented one cycle after commit.
    always_comb begin
        voice_enable_d  = active_q;
        voice_restart_d = restart_pend_q;
        stolen_d        = stolen_pend_q;
        voice_freq_d    = freq_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ev_ready_q      <= 1'b0;
            lat_on_q        <= 1'b0;
            lat_note_q      <= '0;
            lat_freq_q      <= '0;
            idx_q           <= '0;
            match_vld_q     <= 1'b0;
            match_idx_q     <= '0;
            free_vld_q      <= 1'b0;
            free_idx_q      <= '0;
            old_idx_q       <= '0;
            old_age_q       <= '0;
            active_q        <= '0;
            restart_pend_q  <= '0;
            stolen_pend_q   <= 1'b0;
            voice_enable_q  <= '0;
            voice_restart_q <= '0;
            stolen_q        <= 1'b0;
            for (int unsigned v = 0; v < VOICES; v++) begin
                note_q[v]       <= '0;
                freq_q[v]       <= '0;
                age_q[v]        <= AGE_MAX;
                voice_freq_q[v] <= '0;
            end
        end else begin
            ev_ready_q      <= ev_ready_d;
            lat_on_q        <= lat_on_d;
            lat_note_q      <= lat_note_d;
            lat_freq_q      <= lat_freq_d;
            idx_q           <= idx_d;
            match_vld_q     <= match_vld_d;
            match_idx_q     <= match_idx_d;
            free_vld_q      <= free_vld_d;
            free_idx_q      <= free_idx_d;
            old_idx_q       <= old_idx_d;
            old_age_q       <= old_age_d;
            active_q        <= active_d;
            restart_pend_q  <= restart_pend_d;
            stolen_pend_q   <= stolen_pend_d;
            voice_enable_q  <= voice_enable_d;
            voice_restart_q <= voice_restart_d;
            stolen_q        <= stolen_d;
            note_q          <= note_d;
            freq_q          <= freq_d;
            age_q           <= age_d;
            voice_freq_q    <= voice_freq_d;
        end
    end

    assign ev_ready      = ev_ready_q;
    assign voice_enable  = voice_enable_q;
    assign voice_restart = voice_restart_q;
    assign stolen        = stolen_q;
    assign voice_freq    = voice_freq_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized scoreboard bench for voice_allocator (VOICES=4): a note-level model
// predicts each event's visible outcome, a negedge monitor compares every cycle.
module tb_voice_allocator;
    import mypackage::*;

    localparam int NV  = 4;
    localparam int LAT = 7;   // cycles from ready-seen to outputs-visible at negedge

    typedef struct packed {
        int              due;
        logic [3:0]      en;
        logic [3:0][31:0] fr;
        logic [3:0]      rs;
        logic            st;
    } exp_t;

    logic          clock    = 1'b0;
    logic          reset    = 1'b1;
    logic          ev_valid = 1'b0;
    logic          ev_on    = 1'b0;
    logic [6:0]    ev_note  = '0;
    frequency      ev_freq  = '0;
    logic          ev_ready;
    logic          stolen;
    frequency      voice_freq [NV];
    logic [NV-1:0] voice_enable;
    logic [NV-1:0] voice_restart;

    voice_allocator #(.VOICES(4), .NOTE_BITS(7), .AGE_BITS(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .ev_valid      (ev_valid),
        .ev_ready      (ev_ready),
        .ev_on         (ev_on),
        .ev_note       (ev_note),
        .ev_freq       (ev_freq),
        .voice_freq    (voice_freq),
        .voice_enable  (voice_enable),
        .voice_restart (voice_restart),
        .stolen        (stolen)
    );

    always #5 clock = ~clock;

    int   cyc = 0;
    bit   rst_s = 1'b0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb [$];
    int   busy_from = 1;
    int   busy_to = 0;

    // Note-level model: allocation time stamps stand in for voice ages.
    bit          m_active [NV];
    logic [6:0]  m_note [NV];
    frequency    m_freq [NV];
    int          m_last [NV];
    int          on_count;

    logic [3:0]       cur_en = '0;
    logic [3:0][31:0] cur_fr = '0;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        rst_s <= reset;
    end

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
        end
    endfunction

    function automatic frequency hz(input int unsigned h);
        return 32'(h << 16);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NV; i++) begin
            m_active[i] = 1'b0;
            m_note[i]   = '0;
            m_freq[i]   = '0;
            m_last[i]   = -1000;
        end
        on_count = 0;
    endfunction

    function automatic void model_apply(input bit on, input logic [6:0] note, input frequency f, input int due);
        int   match = -1;
        int   free  = -1;
        int   tgt   = -1;
        int   best  = -1;
        exp_t e;
        e = '0;
        for (int i = NV - 1; i >= 0; i--) begin
            if (m_active[i] && m_note[i] == note) match = i;
            if (!m_active[i]) free = i;
        end
        if (on) begin
            if (match >= 0) tgt = match;
            else if (free >= 0) tgt = free;
            else begin
                for (int i = 0; i < NV; i++) begin
                    int age = on_count - m_last[i] - 1;
                    if (age > 15) age = 15;
                    if (age > best) begin
                        best = age;
                        tgt  = i;
                    end
                end
                e.st = 1'b1;
            end
            m_active[tgt] = 1'b1;
            m_note[tgt]   = note;
            m_freq[tgt]   = f;
            m_last[tgt]   = on_count;
            on_count++;
            e.rs[tgt] = 1'b1;
        end else if (match >= 0) begin
            m_active[match] = 1'b0;
        end
        e.due = due;
        for (int i = 0; i < NV; i++) begin
            e.en[i] = m_active[i];
            e.fr[i] = m_freq[i];
        end
        sb.push_back(e);
    endfunction

    // Monitor: pops the expected outcome on its due cycle, otherwise expects steady outputs.
    always @(negedge clock) begin
        if (cyc >= 1) begin
            logic [3:0] exp_rs;
            logic       exp_st;
            exp_rs = '0;
            exp_st = 1'b0;
            if (rst_s) begin
                sb.delete();
                cur_en = '0;
                cur_fr = '0;
                chk("reset_ready", 64'(ev_ready), 64'd0);
            end else begin
                if (sb.size() > 0 && sb[0].due < cyc) begin
                    chk("late_expect", 64'(sb[0].due), 64'(cyc));
                    void'(sb.pop_front());
                end
                if (sb.size() > 0 && sb[0].due == cyc) begin
                    exp_t e;
                    e = sb.pop_front();
                    cur_en = e.en;
                    cur_fr = e.fr;
                    exp_rs = e.rs;
                    exp_st = e.st;
                end
                chk("ready", 64'(ev_ready), 64'(!(cyc >= busy_from && cyc <= busy_to)));
            end
            chk("enable", 64'(voice_enable), 64'(cur_en));
            chk("restart", 64'(voice_restart), 64'(exp_rs));
            chk("stolen", 64'(stolen), 64'(exp_st));
            for (int v = 0; v < NV; v++)
                chk($sformatf("freq%0d", v), 64'(voice_freq[v]), 64'(cur_fr[v]));
        end
    end

    // All driver tasks are entered and left 2 time units after a rising edge.
    task automatic send(input bit on, input logic [6:0] note, input frequency f,
                        input bit keep, output int acc);
        int waited = 0;
        acc      = -1;
        ev_on    = on;
        ev_note  = note;
        ev_freq  = f;
        ev_valid = 1'b1;
        while (ev_ready !== 1'b1) begin
            if (waited == 40) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout cyc=%0d waited=%0d required<40", cyc, waited);
                ev_valid = 1'b0;
                return;
            end
            @(posedge clock); #2;
            waited++;
        end
        model_apply(on, note, f, cyc + LAT);
        busy_from = cyc + 1;
        busy_to   = cyc + 5;
        acc       = cyc + 1;
        @(posedge clock); #2;
        if (!keep) ev_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        ev_valid = 1'b0;
        reset    = 1'b1;
        model_reset();
        repeat (n) begin
            @(posedge clock); #2;
        end
        chk("rst_hold_ready", 64'(ev_ready), 64'd0);
        chk("rst_hold_enable", 64'(voice_enable), 64'd0);
        reset     = 1'b0;
        busy_from = 1;
        busy_to   = 0;
        @(posedge clock); #2;
        chk("rst_release_ready", 64'(ev_ready), 64'd1);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clock); #2;
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int a0, a1, a2;
        model_reset();
        do_reset(3);

        // Single note-on lands on voice 0.
        send(1'b1, 7'd60, hz(440), 1'b0, a0);
        wait_drain();
        chk("t1_enable", 64'(voice_enable), 64'h1);
        chk("t1_freq0", 64'(voice_freq[0]), 64'(hz(440)));

        // Fill all voices, then steal the oldest.
        do_reset(2);
        send(1'b1, 7'd60, hz(262), 1'b0, a0);
        send(1'b1, 7'd62, hz(294), 1'b0, a0);
        send(1'b1, 7'd64, hz(330), 1'b0, a0);
        send(1'b1, 7'd65, hz(349), 1'b0, a0);
        wait_drain();
        chk("t2_full", 64'(voice_enable), 64'hF);
        send(1'b1, 7'd67, hz(392), 1'b0, a0);
        wait_drain();
        chk("t2_steal_freq0", 64'(voice_freq[0]), 64'(hz(392)));

        // Note-off of a playing and a silent note.
        send(1'b0, 7'd62, '0, 1'b0, a0);
        wait_drain();
        chk("t3_off_enable", 64'(voice_enable), 64'hD);
        chk("t3_off_freq1", 64'(voice_freq[1]), 64'(hz(294)));
        send(1'b0, 7'd99, '0, 1'b0, a0);
        wait_drain();
        chk("t3_nomatch", 64'(voice_enable), 64'hD);

        // Retrigger reuses voice 2 even with voice 1 free.
        send(1'b1, 7'd64, hz(333), 1'b0, a0);
        wait_drain();
        chk("t4_retrig_freq2", 64'(voice_freq[2]), 64'(hz(333)));
        chk("t4_retrig_freq1", 64'(voice_freq[1]), 64'(hz(294)));

        // Back-to-back with ev_valid held high.
        send(1'b1, 7'd70, hz(500), 1'b1, a0);
        send(1'b1, 7'd71, hz(510), 1'b1, a1);
        send(1'b0, 7'd70, '0, 1'b0, a2);
        chk("t5_spacing01", 64'(a1 - a0), 64'd6);
        chk("t5_spacing12", 64'(a2 - a1), 64'd6);
        wait_drain();

        // A request withdrawn while busy is never taken.
        send(1'b1, 7'd80, hz(600), 1'b0, a0);
        ev_on = 1'b1; ev_note = 7'd81; ev_freq = hz(601); ev_valid = 1'b1;
        repeat (2) begin
            @(posedge clock); #2;
        end
        ev_valid = 1'b0;
        wait_drain();
        repeat (4) begin
            @(posedge clock); #2;
        end

        // Reset in the middle of a scan.
        send(1'b1, 7'd72, hz(700), 1'b0, a0);
        do_reset(2);
        repeat (8) begin
            @(posedge clock); #2;
        end

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 160; k++) begin
            bit         on, keep;
            logic [6:0] note;
            if ($urandom_range(0, 39) == 0) do_reset(int'($urandom_range(1, 3)));
            on   = ($urandom_range(0, 99) < 65);
            note = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : 7'(60 + $urandom_range(0, 7));
            keep = ($urandom_range(0, 2) == 0);
            send(on, note, frequency'($urandom), keep, a0);
            if (!keep) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clock); #2;
                end
            end
        end
        ev_valid = 1'b0;
        wait_drain();
        repeat (4) begin
            @(posedge clock); #2;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog cyc=%0d got=running exp=finished", cyc);
        $fatal(1, "watchdog");
    end

endmodule
